wb_sequencer: RTL and testbench
===============================

WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 32, max cycles waited for a source-ready signal before abandoning writeback.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  one-cycle request to perform a register writeback.
REQ-005 SHALL have port: wb_class  input  3  source select: 000 LS, 001 HI, 010 LO, 011 SHIFT, 100 CONST227, 101 SE1_32, 110 ALUOUT, 111 invalid.
REQ-006 SHALL have port: wb_dest  input  5  destination register number, sampled with start.
REQ-007 SHALL have port: ls_done  input  1  load/store unit data valid.
REQ-008 SHALL have port: md_done  input  1  mult/div result valid in HI/LO.
REQ-009 SHALL have port: shift_done  input  1  shift register result valid.
REQ-010 SHALL have port: abort  input  1  cancel the in-flight writeback (exception/flush).
REQ-011 SHALL have port: DataSrcControl  output  3  writeback data mux select.
REQ-012 SHALL have port: RegWrite  output  1  register file write enable.
REQ-013 SHALL have port: wb_addr  output  5  register file write address.
REQ-014 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port: err  output  1  one-cycle pulse on timeout or invalid class, coincident with done.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_SRC, WRITE.
REQ-018 IDLE + start: SHALL latch wb_class and wb_dest; go to WRITE for classes 100/101/110, to WAIT_SRC for 000/001/010/011.
REQ-019 IDLE + start + class 111: SHALL stay in IDLE, pulse done and err next cycle, no write.
REQ-020 WAIT_SRC: SHALL watch only the matching ready (000 ls_done, 001/010 md_done, 011 shift_done); on that ready go to WRITE next cycle.
REQ-021 WAIT_SRC: SHALL count waited cycles with a $clog2(TIMEOUT_CYCLES+1)-bit counter cleared on entry; if count reaches TIMEOUT_CYCLES without ready, go to IDLE and pulse done+err, no write.
REQ-022 WRITE: SHALL assert RegWrite for exactly one cycle with wb_addr=latched dest and DataSrcControl=latched class, then go to IDLE and pulse done in that same WRITE cycle.
REQ-023 latched dest 0: SHALL suppress RegWrite, still pulse done, err low.
REQ-024 DataSrcControl SHALL equal latched class from the cycle after start until leaving WRITE; 3'b110 in IDLE.
REQ-025 Latency: immediate classes -> RegWrite in cycle start+1; waiting classes -> RegWrite one cycle after ready sampled high.
REQ-026 start while busy SHALL be ignored (no queueing).
REQ-027 abort in WAIT_SRC or WRITE SHALL force IDLE next edge, RegWrite low in that cycle, no done, no err; abort beats ready, timeout and write in the same cycle.
REQ-028 Ready asserted in the same cycle as start SHALL NOT be consumed; WAIT_SRC samples from the following cycle.

Reset
REQ-029 reset SHALL immediately force IDLE, counter 0, latched class 3'b110, latched dest 0.
REQ-030 During and after reset: DataSrcControl=3'b110, RegWrite=0, wb_addr=0, busy=0, done=0, err=0; reset mid-operation SHALL drop the writeback silently.

Structure
REQ-031 Shared package wb_pkg SHALL hold the 3-bit source-select encodings, the FSM state enum and the default TIMEOUT_CYCLES constant; the DataSrc mux SHALL use the same encodings.
REQ-032 One sub-module wb_timeout (loadable cycle counter with clear, enable, expired flag) is natural; the FSM stays in wb_sequencer.

Verification
REQ-033 start, class 110, dest 8 at cycle 0 -> cycle 1: RegWrite=1, wb_addr=8, DataSrcControl=110, done=1; cycle 2 idle.
REQ-034 start, class 000, dest 9; ls_done high at cycle 4 -> RegWrite=1 with DataSrcControl=000 at cycle 5 only.
REQ-035 start, class 001, md_done never asserted -> done=1, err=1 at cycle 33 (TIMEOUT_CYCLES=32), RegWrite never high.
REQ-036 start, class 011, dest 0, shift_done at cycle 2 -> done at cycle 3, RegWrite=0.
REQ-037 start, class 010; abort with md_done at cycle 3 -> IDLE at cycle 4, no RegWrite, no done; second start accepted at cycle 4.
REQ-038 reset pulsed during WAIT_SRC -> outputs at reset values immediately, no write after release; class 111 start -> done+err at next cycle.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared encodings for the writeback sequencer. This package
//               holds the writeback source selects, the FSM state codes and
//               the default source-ready timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Writeback source selects, also used as the DataSrc mux encoding
    localparam logic [2:0] c_SRC_LS       = 3'b000;
    localparam logic [2:0] c_SRC_HI       = 3'b001;
    localparam logic [2:0] c_SRC_LO       = 3'b010;
    localparam logic [2:0] c_SRC_SHIFT    = 3'b011;
    localparam logic [2:0] c_SRC_CONST227 = 3'b100;
    localparam logic [2:0] c_SRC_SE1_32   = 3'b101;
    localparam logic [2:0] c_SRC_ALUOUT   = 3'b110;
    localparam logic [2:0] c_SRC_INVALID  = 3'b111;

    // Sequencer FSM state encoding
    localparam logic [1:0] c_ST_IDLE     = 2'b00;
    localparam logic [1:0] c_ST_WAIT_SRC = 2'b01;
    localparam logic [1:0] c_ST_WRITE    = 2'b10;

    // Default number of cycles to wait for a source before giving up
    localparam int c_TIMEOUT_CYCLES_DEFAULT = 32;

    // Sources whose data is already available and need no ready handshake
    function automatic logic is_immediate(input logic [2:0] cls);
        return (cls == c_SRC_CONST227) || (cls == c_SRC_SE1_32) ||
               (cls == c_SRC_ALUOUT);
    endfunction

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_timeout.sv
`default_nettype none
// ============================================================================
// Module      : wb_timeout
// Description : Saturating wait-cycle counter with a synchronous clear, a
//               count enable and an expired flag. The flag rises once LIMIT
//               enabled cycles have been counted since the last clear.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout #(
    parameter int LIMIT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int                 c_CNT_W = $clog2(LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(LIMIT);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_count;
    logic               w_at_limit;

    assign w_at_limit = (r_count == c_LIMIT);
    assign o_expired  = w_at_limit;

    // Count enabled cycles, holding at the limit so the counter never wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_at_limit) begin
            r_count <= r_count + c_ONE;
        end
    end

endmodule : wb_timeout
`default_nettype wire

// File: rtl/wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : wb_sequencer
// Description : Register writeback sequencer. This module accepts a one-cycle
//               writeback request and waits for the selected source to become
//               ready when needed. It then issues a single register-file write
//               and pulses done. Timeouts and invalid sources pulse err with
//               done. Abort drops the writeback silently.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] wb_class,
    input  logic [4:0] wb_dest,
    input  logic       ls_done,
    input  logic       md_done,
    input  logic       shift_done,
    input  logic       abort,
    output logic [2:0] DataSrcControl,
    output logic       RegWrite,
    output logic [4:0] wb_addr,
    output logic       busy,
    output logic       done,
    output logic       err
);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [2:0] r_class;
    logic [4:0] r_dest;
    logic       r_invalid;
    logic       w_accept;
    logic       w_ready;
    logic       w_expired;
    logic       w_in_idle;
    logic       w_in_wait;
    logic       w_in_write;
    logic       w_timeout;

    assign w_in_idle  = (r_state == c_ST_IDLE);
    assign w_in_wait  = (r_state == c_ST_WAIT_SRC);
    assign w_in_write = (r_state == c_ST_WRITE);

    // A request is only taken when idle and the source select is legal
    assign w_accept = w_in_idle && start && (wb_class != c_SRC_INVALID);

    // Select the ready line belonging to the latched source
    always_comb begin
        w_ready = 1'b0;
        case (r_class)
            c_SRC_LS:           w_ready = ls_done;
            c_SRC_HI, c_SRC_LO: w_ready = md_done;
            c_SRC_SHIFT:        w_ready = shift_done;
            default:            w_ready = 1'b0;
        endcase
    end

    // The counter is held clear while idle, so it starts from zero on entry to WAIT_SRC
    wb_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (w_in_idle),
        .i_enable  (w_in_wait),
        .o_expired (w_expired)
    );

    // Ready wins over timeout, and abort wins over everything
    assign w_timeout = w_in_wait && !abort && !w_ready && w_expired;

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = is_immediate(wb_class) ? c_ST_WRITE : c_ST_WAIT_SRC;
                end
            end
            c_ST_WAIT_SRC: begin
                if (abort) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_ready) begin
                    w_state_nxt = c_ST_WRITE;
                end else if (w_expired) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_WRITE: w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the source select and destination of an accepted request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_class <= c_SRC_ALUOUT;
            r_dest  <= 5'd0;
        end else if (w_accept) begin
            r_class <= wb_class;
            r_dest  <= wb_dest;
        end
    end

    // An invalid request is answered one cycle later with done and err
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_invalid <= 1'b0;
        end else begin
            r_invalid <= w_in_idle && start && (wb_class == c_SRC_INVALID);
        end
    end

    // Register $zero is never written, but the writeback still completes
    assign RegWrite       = w_in_write && !abort && (r_dest != 5'd0);
    assign wb_addr        = w_in_idle ? 5'd0 : r_dest;
    assign DataSrcControl = w_in_idle ? c_SRC_ALUOUT : r_class;
    assign busy           = !w_in_idle;
    assign done           = (w_in_write && !abort) || w_timeout || r_invalid;
    assign err            = w_timeout || r_invalid;

endmodule : wb_sequencer
`default_nettype wire

// File: tb/tb_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_sequencer
// Description : Self-checking bench for wb_sequencer. A transaction-level
//               model predicts every output on every cycle. Directed
//               scenarios pin the model with literal expectations, and a
//               randomized phase follows them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_sequencer;

    localparam int TO = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] wb_class;
    logic [4:0] wb_dest;
    logic       ls_done;
    logic       md_done;
    logic       shift_done;
    logic       abort;
    logic [2:0] DataSrcControl;
    logic       RegWrite;
    logic [4:0] wb_addr;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_errs   = 0;

    wb_sequencer #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .wb_class       (wb_class),
        .wb_dest        (wb_dest),
        .ls_done        (ls_done),
        .md_done        (md_done),
        .shift_done     (shift_done),
        .abort          (abort),
        .DataSrcControl (DataSrcControl),
        .RegWrite       (RegWrite),
        .wb_addr        (wb_addr),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Ready line that a waiting source class listens to
    function automatic logic src_ready(input logic [2:0] c);
        case (c)
            3'd0:       return ls_done;
            3'd1, 3'd2: return md_done;
            3'd3:       return shift_done;
            default:    return 1'b0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Reference model: one pending transaction described by its start
    // cycle and, once known, the cycle in which it writes.
    // ------------------------------------------------------------------
    int         n     = 0;
    bit         m_act = 0;
    bit         m_inv = 0;
    logic [2:0] m_cls = 3'd6;
    logic [4:0] m_dst = 5'd0;
    int         m_t   = 0;
    int         m_wr  = -1;

    always @(negedge clk) begin
        bit         was_act;
        bit         fin;
        logic       e_busy, e_rw, e_done, e_err;
        logic [2:0] e_dsc;
        was_act = m_act;
        fin     = 0;
        e_busy  = 0;
        e_rw    = 0;
        e_done  = 0;
        e_err   = 0;
        e_dsc   = 3'b110;
        if (reset) begin
            m_act = 0;
            m_inv = 0;
            chk("rst_busy", busy, 0);
            chk("rst_regwrite", RegWrite, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_dsc", DataSrcControl, 3'b110);
            chk("rst_addr", wb_addr, 0);
        end else begin
            if (m_inv) begin
                e_done = 1;
                e_err  = 1;
            end
            if (m_act) begin
                e_busy = 1;
                e_dsc  = m_cls;
                if (n == m_wr) begin
                    e_rw   = (m_dst != 0) && !abort;
                    e_done = !abort;
                    fin    = 1;
                end else if (abort) begin
                    fin = 1;
                end else if (src_ready(m_cls)) begin
                    m_wr = n + 1;
                end else if (n - (m_t + 1) == TO) begin
                    e_done = 1;
                    e_err  = 1;
                    fin    = 1;
                end
            end
            chk("busy", busy, e_busy);
            chk("regwrite", RegWrite, e_rw);
            chk("done", done, e_done);
            chk("err", err, e_err);
            chk("dsc", DataSrcControl, e_dsc);
            if (e_rw) chk("wb_addr", wb_addr, m_dst);
            m_inv = 0;
            if (fin) m_act = 0;
            if (!was_act && start) begin
                if (wb_class == 3'd7) begin
                    m_inv = 1;
                end else begin
                    m_act = 1;
                    m_cls = wb_class;
                    m_dst = wb_dest;
                    m_t   = n;
                    m_wr  = (wb_class >= 3'd4) ? n + 1 : -1;
                end
            end
        end
        n++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start      = 0;
        ls_done    = 0;
        md_done    = 0;
        shift_done = 0;
        abort      = 0;
    endtask

    task automatic req(input logic [2:0] c, input logic [4:0] d);
        start    = 1;
        wb_class = c;
        wb_dest  = d;
        cyc();
        start = 0;
    endtask

    // Directed scenarios with literal expectations, then random traffic
    initial begin
        reset    = 1;
        wb_class = 3'd0;
        wb_dest  = 5'd0;
        quiet();
        cyc();
        cyc();
        chk("lit_rst_busy", busy, 0);
        chk("lit_rst_dsc", DataSrcControl, 3'b110);
        chk("lit_rst_addr", wb_addr, 0);
        chk("lit_rst_rw", RegWrite, 0);
        reset = 0;
        cyc();

        // Immediate ALUOUT writeback to r8
        req(3'b110, 5'd8);
        #1;
        chk("imm_rw", RegWrite, 1);
        chk("imm_addr", wb_addr, 8);
        chk("imm_dsc", DataSrcControl, 3'b110);
        chk("imm_done", done, 1);
        cyc();
        chk("imm_idle", busy, 0);
        chk("imm_rw_once", RegWrite, 0);

        // Load/store source, ready in cycle 4, write in cycle 5
        req(3'b000, 5'd9);
        cyc();
        cyc();
        cyc();
        ls_done = 1;
        #1;
        chk("ls_rw_c4", RegWrite, 0);
        cyc();
        ls_done = 0;
        #1;
        chk("ls_rw_c5", RegWrite, 1);
        chk("ls_dsc", DataSrcControl, 3'b000);
        chk("ls_addr", wb_addr, 9);
        cyc();
        chk("ls_rw_c6", RegWrite, 0);

        // HI source that never becomes ready: timeout in cycle 33
        req(3'b001, 5'd3);
        repeat (31) cyc();
        chk("to_done_c32", done, 0);
        cyc();
        chk("to_done_c33", done, 1);
        chk("to_err_c33", err, 1);
        chk("to_rw_c33", RegWrite, 0);
        cyc();
        chk("to_idle", busy, 0);

        // Shift source to r0: completes without a write
        req(3'b011, 5'd0);
        cyc();
        shift_done = 1;
        cyc();
        shift_done = 0;
        #1;
        chk("r0_done", done, 1);
        chk("r0_rw", RegWrite, 0);
        chk("r0_err", err, 0);
        cyc();

        // Abort together with ready, then a new request is accepted
        req(3'b010, 5'd4);
        cyc();
        cyc();
        abort   = 1;
        md_done = 1;
        #1;
        chk("ab_done", done, 0);
        chk("ab_rw", RegWrite, 0);
        cyc();
        abort   = 0;
        md_done = 0;
        #1;
        chk("ab_idle", busy, 0);
        req(3'b110, 5'd5);
        #1;
        chk("ab_next_rw", RegWrite, 1);
        chk("ab_next_addr", wb_addr, 5);
        cyc();

        // Reset while waiting drops the writeback, then an invalid class
        req(3'b000, 5'd7);
        cyc();
        chk("mr_busy", busy, 1);
        reset = 1;
        #1;
        chk("mr_busy_now", busy, 0);
        chk("mr_dsc_now", DataSrcControl, 3'b110);
        chk("mr_addr_now", wb_addr, 0);
        chk("mr_done_now", done, 0);
        cyc();
        reset   = 0;
        ls_done = 1;
        cyc();
        cyc();
        chk("mr_no_write", RegWrite, 0);
        ls_done = 0;
        req(3'b111, 5'd3);
        #1;
        chk("inv_done", done, 1);
        chk("inv_err", err, 1);
        chk("inv_busy", busy, 0);
        chk("inv_rw", RegWrite, 0);
        cyc();

        // Random traffic: ready density drops by phase so timeouts occur
        for (int i = 0; i < 4500; i++) begin
            int ph;
            bit rdy_on;
            ph         = (i / 500) % 3;
            start      = ($urandom_range(3) == 0);
            wb_class   = 3'($urandom);
            wb_dest    = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
            rdy_on     = (ph == 0) ? ($urandom_range(3) == 0) :
                         (ph == 1) ? ($urandom_range(15) == 0) : 1'b0;
            ls_done    = rdy_on && $urandom_range(1) == 0;
            md_done    = rdy_on && $urandom_range(1) == 0;
            shift_done = rdy_on && $urandom_range(1) == 0;
            abort      = ($urandom_range(23) == 0);
            reset      = ($urandom_range(399) == 0);
            cyc();
        end
        reset = 0;
        quiet();
        cyc();
        cyc();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule : tb_wb_sequencer
`default_nettype wire
